// File: rtl/shift_reg_pkg.sv
// Shared definitions for the 4-entry sample shift register and its read-side
// sequencer: window depth, address/fill widths and the sweep state encoding.
package shift_reg_pkg;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int FILL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_reader.sv
// Read-side sequencer for the sample shift register. Counts loaded samples,
// and once a full window exists, sweeps it oldest-first on every new load,
// streaming the words out on a valid/ready interface with a last marker.
// A load arriving mid-sweep restarts the sweep and pulses overrun.
module shift_reg_reader
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_in_sync,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic [ADDR_W-1:0]     fifo_r_address,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    capture;

  // A word is taken from the register only when no shift is happening this
  // edge and the output stage is empty or being drained.
  assign capture = (state_q == SWEEP) && !load_in_sync &&
                   (!out_valid_q || out_ready);

  // Next-state logic for the sweep FSM, sweep position and fill counter.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    overrun_d = 1'b0;

    if (load_in_sync && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (load_in_sync && (fill_q >= FILL_ARM)) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (load_in_sync) begin
          // The window shifted under us: restart on the new window.
          idx_d     = '0;
          overrun_d = 1'b1;
        end else if (capture) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-state logic for the output holding stage.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (capture) begin
      out_data_d  = fifo_r_data;
      out_valid_d = 1'b1;
      out_last_d  = (idx_q == IDX_LAST);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // FSM, sweep position and fill counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      fill_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      overrun_q <= overrun_d;
    end
  end

  // Output stage registers; data and last hold until the word is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign fifo_r_address = IDX_LAST - idx_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q == SWEEP);

endmodule : shift_reg_reader
